// File: rtl/usi_csr_arbiter.sv
// Round-robin arbiter sharing the SPIBlock Usi slave CSR port between internal requesters.
// Define USI_ARB_TIMEOUT_EN to build the read-wait timeout counter and oReqErr reporting.
module usi_csr_arbiter #(
   parameter int unsigned pReqNum       = 4,
   parameter int unsigned pUsiBusWidth  = 16,
   parameter int unsigned pTimeoutCycle = 255
) (
   input  logic                            iSCLK,
   input  logic                            iSRST,
   input  logic [pReqNum-1:0]              iReqVd,
   input  logic [pReqNum-1:0]              iReqRnW,
   input  logic [32*pReqNum-1:0]           iReqWd,
   input  logic [pUsiBusWidth*pReqNum-1:0] iReqAdrs,
   output logic [pReqNum-1:0]              oReqGrant,
   output logic [pReqNum-1:0]              oReqDone,
   output logic [31:0]                     oReqRd,
   output logic                            oReqErr,
   output logic [31:0]                     oSUsiWd,
   output logic [pUsiBusWidth-1:0]         oSUsiAdrs,
   output logic                            oSUsiWCke,
   input  logic [31:0]                     iSUsiRd,
   input  logic                            iSUsiREd,
   input  logic                            iMUsiSel
);
   localparam int unsigned cIdxW = $clog2(pReqNum);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   state_t                  state_q, state_d;
   logic [cIdxW-1:0]        ptr_q, ptr_d;
   logic [cIdxW-1:0]        win_q, win_d;
   logic                    rnw_q, rnw_d;
   logic [pReqNum-1:0]      grant_q, grant_d;
   logic [pReqNum-1:0]      done_q, done_d;
   logic [31:0]             rd_q, rd_d;
   logic [31:0]             wd_q, wd_d;
   logic [pUsiBusWidth-1:0] adrs_q, adrs_d;
   logic                    wcke_q, wcke_d;
`ifdef USI_ARB_TIMEOUT_EN
   logic                    err_q, err_d;
   logic [7:0]              cnt_q, cnt_d;
`endif

   logic                    pick_vld;
   logic [cIdxW-1:0]        pick_idx;
   logic [cIdxW-1:0]        cand;
   logic [pReqNum-1:0]      pick_oh;
   logic [31:0]             sel_wd;
   logic [pUsiBusWidth-1:0] sel_adrs;
   logic                    sel_rnw;

   // Rotating priority search starting at the pointer, then mux the winner's fields
   always_comb begin
      pick_vld = 1'b0;
      pick_idx = '0;
      cand     = '0;
      for (int unsigned k = 0; k < pReqNum; k++) begin
         cand = cIdxW'((32'(ptr_q) + k) % pReqNum);
         if (!pick_vld && iReqVd[cand]) begin
            pick_vld = 1'b1;
            pick_idx = cand;
         end
      end
      pick_oh  = '0;
      sel_wd   = '0;
      sel_adrs = '0;
      sel_rnw  = 1'b0;
      for (int unsigned k = 0; k < pReqNum; k++) begin
         if (32'(pick_idx) == k) begin
            pick_oh[k] = 1'b1;
            sel_wd     = iReqWd[32*k +: 32];
            sel_adrs   = iReqAdrs[pUsiBusWidth*k +: pUsiBusWidth];
            sel_rnw    = iReqRnW[k];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      win_d   = win_q;
      rnw_d   = rnw_q;
      grant_d = grant_q;
      done_d  = done_q;
      rd_d    = rd_q;
      wd_d    = wd_q;
      adrs_d  = adrs_q;
      wcke_d  = 1'b0;
`ifdef USI_ARB_TIMEOUT_EN
      err_d   = err_q;
      cnt_d   = cnt_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (!iMUsiSel && pick_vld) begin
               win_d   = pick_idx;
               rnw_d   = sel_rnw;
               wd_d    = sel_wd;
               adrs_d  = sel_adrs;
               wcke_d  = 1'b1;
               grant_d = pick_oh;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            if (rnw_q) begin
               state_d = WAIT;
`ifdef USI_ARB_TIMEOUT_EN
               cnt_d   = '0;
`endif
            end else begin
               done_d  = grant_q;
`ifdef USI_ARB_TIMEOUT_EN
               err_d   = 1'b0;
`endif
               state_d = DONE;
            end
         end
         WAIT: begin
            if (iSUsiREd) begin
               rd_d    = iSUsiRd;
               done_d  = grant_q;
`ifdef USI_ARB_TIMEOUT_EN
               err_d   = 1'b0;
`endif
               state_d = DONE;
            end
`ifdef USI_ARB_TIMEOUT_EN
            else if (cnt_q == 8'(pTimeoutCycle)) begin
               rd_d    = '0;
               err_d   = 1'b1;
               done_d  = grant_q;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
`endif
         end
         DONE: begin
            grant_d = '0;
            done_d  = '0;
            ptr_d   = (32'(win_q) == pReqNum - 1) ? '0 : win_q + cIdxW'(1);
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge iSCLK or posedge iSRST) begin
      if (iSRST) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         win_q   <= '0;
         rnw_q   <= 1'b0;
         grant_q <= '0;
         done_q  <= '0;
         rd_q    <= '0;
         wd_q    <= '0;
         adrs_q  <= '0;
         wcke_q  <= 1'b0;
`ifdef USI_ARB_TIMEOUT_EN
         err_q   <= 1'b0;
         cnt_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         win_q   <= win_d;
         rnw_q   <= rnw_d;
         grant_q <= grant_d;
         done_q  <= done_d;
         rd_q    <= rd_d;
         wd_q    <= wd_d;
         adrs_q  <= adrs_d;
         wcke_q  <= wcke_d;
`ifdef USI_ARB_TIMEOUT_EN
         err_q   <= err_d;
         cnt_q   <= cnt_d;
`endif
      end
   end

   assign oReqGrant = grant_q;
   assign oReqDone  = done_q;
   assign oReqRd    = rd_q;
   assign oSUsiWd   = wd_q;
   assign oSUsiAdrs = adrs_q;
   assign oSUsiWCke = wcke_q;
`ifdef USI_ARB_TIMEOUT_EN
   assign oReqErr   = err_q;
`else
   assign oReqErr   = 1'b0;
`endif

endmodule

// File: tb/tb_usi_csr_arbiter.sv
// Bench for usi_csr_arbiter: transaction-level round-robin model plus a Usi read responder.
`timescale 1ns/1ps
module tb_usi_csr_arbiter;
   localparam int N  = 4;
   localparam int AW = 16;
   localparam int TO = 16;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    vd, rnw;
   logic [32*N-1:0] wd;
   logic [AW*N-1:0] adrs;
   logic [N-1:0]    grant, done;
   logic [31:0]     rd, swd, srd;
   logic            err, swcke, sred, sel;
   logic [AW-1:0]   sadrs;

   usi_csr_arbiter #(.pReqNum(N), .pUsiBusWidth(AW), .pTimeoutCycle(TO)) dut (
      .iSCLK(clk), .iSRST(rst), .iReqVd(vd), .iReqRnW(rnw), .iReqWd(wd), .iReqAdrs(adrs),
      .oReqGrant(grant), .oReqDone(done), .oReqRd(rd), .oReqErr(err),
      .oSUsiWd(swd), .oSUsiAdrs(sadrs), .oSUsiWCke(swcke),
      .iSUsiRd(srd), .iSUsiREd(sred), .iMUsiSel(sel)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s obs=%0h exp=%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic logic [N-1:0] oh(input int i);
      logic [N-1:0] v;
      v = '0;
      v[i] = 1'b1;
      return v;
   endfunction

   function automatic int rr_pick(input int p, input logic [N-1:0] v);
      for (int i = 0; i < N; i++)
         if (v[(p + i) % N]) return (p + i) % N;
      return -1;
   endfunction

   // Stimulus-owned controls
   int          post[N];
   int          fix_d = -1;
   bit          rsp_off = 1'b0;
   bit          fix_rd_en = 1'b0;
   logic [31:0] fix_rd = '0;
   int          bound_hits = 0;

   // Model/monitor-owned state
   int          cyc = 0;
   int          served[N];
   bit          busy = 1'b0;
   int          mptr = 0, mwin = 0, dcyc = 0, free_from = 0;
   bit          mrnw, merr;
   logic [31:0] mrd;
   bit          rsp_pend = 1'b0;
   int          rsp_cyc = 0;
   logic [31:0] rsp_data;
   int          pick, d, bh_seen = 0;
   logic [N-1:0]    prev_vd = '0, prev_rnw = '0;
   logic [32*N-1:0] prev_wd = '0;
   logic [AW*N-1:0] prev_adrs = '0;
   bit              prev_sel = 1'b0;

   always @(negedge clk) begin
      cyc++;
      if (rst) begin
         chk("rst_grant", grant, 0);
         chk("rst_done", done, 0);
         chk("rst_rd", rd, 0);
         chk("rst_err", err, 0);
         chk("rst_wd", swd, 0);
         chk("rst_adrs", sadrs, 0);
         chk("rst_wcke", swcke, 0);
         busy = 1'b0; mptr = 0; rsp_pend = 1'b0; free_from = cyc + 2;
         sred = 1'b0; srd = '0;
      end else begin
         pick = rr_pick(mptr, prev_vd);
         if (!busy && cyc >= free_from && !prev_sel && pick >= 0) begin
            busy = 1'b1; mwin = pick; mrnw = prev_rnw[pick];
            chk("wcke", swcke, 1);
            chk("adrs", sadrs, prev_adrs[pick*AW +: AW]);
            chk("wd", swd, prev_wd[pick*32 +: 32]);
            merr = 1'b0; mrd = '0;
            if (!mrnw) begin
               dcyc = cyc + 1;
            end else begin
               d = (fix_d >= 0) ? fix_d : int'($urandom_range(1, 6));
               rsp_data = fix_rd_en ? fix_rd : $urandom;
               rsp_pend = !rsp_off;
               rsp_cyc  = cyc + d;
`ifdef USI_ARB_TIMEOUT_EN
               if (rsp_pend && d <= TO + 1) begin
                  dcyc = cyc + d + 1; mrd = rsp_data;
               end else begin
                  dcyc = cyc + TO + 2; merr = 1'b1;
               end
`else
               dcyc = rsp_pend ? cyc + d + 1 : cyc + 1000000;
               mrd  = rsp_data;
`endif
            end
         end else begin
            chk("wcke", swcke, 0);
         end
         chk("grant", grant, busy ? oh(mwin) : '0);
         chk("done", done, (busy && cyc == dcyc) ? oh(mwin) : '0);
         if (busy && cyc == dcyc) begin
            if (mrnw) chk("rd", rd, mrd);
            chk("err", err, merr);
            busy = 1'b0; free_from = cyc + 2;
            mptr = (mwin + 1) % N;
            served[mwin]++;
         end
         sred = 1'b0; srd = $urandom;
         if (rsp_pend && cyc == rsp_cyc) begin
            sred = 1'b1; srd = rsp_data; rsp_pend = 1'b0;
         end
      end
      for (int k = 0; k < N; k++) vd[k] = (post[k] > served[k]);
      prev_vd = vd; prev_rnw = rnw; prev_wd = wd; prev_adrs = adrs; prev_sel = sel;
      if (bound_hits != bh_seen) begin
         chk("wait_bound", bound_hits, bh_seen);
         bh_seen = bound_hits;
      end
   end

   task automatic post_req(input int k, input bit r, input logic [15:0] a, input logic [31:0] w, input int n);
      rnw[k]           = r;
      adrs[k*AW +: AW] = a;
      wd[k*32 +: 32]   = w;
      post[k]          = post[k] + n;
   endtask

   function automatic bit all_idle();
      for (int k = 0; k < N; k++) if (post[k] != served[k]) return 1'b0;
      return !busy;
   endfunction

   task automatic wait_idle(input int max);
      for (int i = 0; i < max; i++) begin
         @(posedge clk); #2;
         if (all_idle()) return;
      end
      bound_hits++;
   endtask

   initial begin
      rst = 1'b1; sel = 1'b0; rnw = '0; wd = '0; adrs = '0;
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;

      // Round robin: every requester reasserts once after its done
      @(posedge clk); #2;
      for (int k = 0; k < N; k++) post_req(k, 1'b0, 16'h0300 + 16'(k), 32'h1000 + 32'(k), 2);
      wait_idle(100);

      // Single write
      post_req(0, 1'b0, 16'h0304, 32'h0000_0008, 1);
      wait_idle(50);

      // Read returning 0xAA five cycles after WCke
      fix_d = 5; fix_rd = 32'h0000_00AA; fix_rd_en = 1'b1;
      post_req(2, 1'b1, 16'h0308, 32'h0, 1);
      wait_idle(50);
      fix_rd_en = 1'b0; fix_d = -1;

      // Bus owned by SPI blocks the grant until released
      sel = 1'b1;
      post_req(1, 1'b0, 16'h0310, 32'hDEAD_BEEF, 1);
      repeat (6) @(posedge clk);
      #2 sel = 1'b0;
      wait_idle(50);

      // Ownership taken mid read still lets that read complete
      fix_d = 4;
      post_req(1, 1'b1, 16'h0314, 32'h0, 1);
      for (int i = 0; i < 20 && !busy; i++) @(posedge clk);
      @(posedge clk); #2 sel = 1'b1;
      wait_idle(50);
      sel = 1'b0; fix_d = -1;

`ifdef USI_ARB_TIMEOUT_EN
      rsp_off = 1'b1;
      post_req(2, 1'b1, 16'h0320, 32'h0, 1);
      wait_idle(60);
      rsp_off = 1'b0;
      fix_d = TO + 1;
      post_req(2, 1'b1, 16'h0324, 32'h0, 1);
      wait_idle(60);
      fix_d = TO + 2;
      post_req(2, 1'b1, 16'h0328, 32'h0, 1);
      wait_idle(60);
      fix_d = -1;
`endif

      // Async reset during a read WAIT; pending requests restart from pointer 0
      rsp_off = 1'b1;
      post_req(3, 1'b1, 16'h0330, 32'h0, 1);
      for (int i = 0; i < 20 && !busy; i++) @(posedge clk);
      repeat (3) @(posedge clk);
      #2 post_req(1, 1'b0, 16'h0334, 32'h1234_5678, 1);
      @(posedge clk); #2 rst = 1'b1; rsp_off = 1'b0;
      @(posedge clk); #2 rst = 1'b0;
      wait_idle(100);

      // Randomized traffic
      repeat (400) begin
         @(posedge clk); #2;
         sel = ($urandom_range(0, 9) == 0);
         for (int k = 0; k < N; k++)
            if (post[k] == served[k] && $urandom_range(0, 2) == 0)
               post_req(k, 1'($urandom_range(0, 1)), 16'($urandom), $urandom, 1);
      end
      sel = 1'b0;
      wait_idle(300);
      repeat (2) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
